seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Iterative shift-add multiplier, the companion of the sequential divider in the arithmetic unit.
//  Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, one multiplier bit per clock.
//  Handshake is start/fin: the product is held stable and fin stays high until the next accepted start.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk     in   1        rising-edge clock; sole clock
//  reset   in   1        asynchronous, active-high; clears all state
//  start   in   1        request; sampled on rising clk; accepted only in IDLE or DONE
//  mcand   in   WIDTH    multiplicand; captured on accepted start
//  mplier  in   WIDTH    multiplier; captured on accepted start
//  prod    out  2*WIDTH  product register; updated only on the finishing edge
//  fin     out  1        registered; high from the finishing edge until the next accepted start
//  busy    out  1        registered; high while in RUN
// BEHAVIOUR
//  Reset (async, any time, including mid-RUN): state=IDLE; prod=0, fin=0, busy=0, acc=0, rep=0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE -> RUN on start. DONE -> RUN on start. RUN ignores start; inputs are not re-sampled.
//   RUN -> DONE on the edge that performs iteration WIDTH.
//  Accept (edge k): latch mcand to mc_q. Load acc[2W:0] = {1'b0, W'b0, mplier}. rep=0. busy=1, fin=0.
//   prod keeps its old value.
//  Iteration (edges k+1 .. k+W), one per edge:
//   hi = acc[2W-1:W] + (acc[0] ? mc_q : 0), computed W+1 bits wide;
//   acc = {hi, acc[W-1:1]} >> 0, i.e. logical right shift of {carry,hi,lo} by 1; rep = rep+1.
//  Edge k+W: prod = final acc[2W-1:0]; fin=1; busy=0; state=DONE. Latency = WIDTH cycles after accept.
//  Arithmetic is unsigned and exact. The carry bit prevents overflow, so no wrap is possible.
//  Boundary values: 0*x = 0 and max*max = 2^(2W) - 2^(W+1) + 1; both take the full WIDTH cycles.
//   There is no early exit.
//  start held high continuously: a new multiply is re-accepted on the edge after each DONE.
//   fin then pulses for one cycle per result.
//  rep is a $clog2(WIDTH+1)-bit counter and never wraps; it is compared against WIDTH.
// CONFIGURATION
//  SEQ_MULT_SIGNED_EN defined: operands are two's complement; the product is two's complement.
//   On accept, magnitudes |mcand| and |mplier| are latched, plus neg = mcand[W-1]^mplier[W-1].
//   On the finishing edge, prod = neg ? -acc : acc.
//   -2^(W-1) is handled: its magnitude 2^(W-1) fits in W unsigned bits.
//   Latency is unchanged (W cycles).
//  SEQ_MULT_SIGNED_EN undefined: pure unsigned; no sign logic is present.
// STRUCTURE
//  Package mult_pkg holds:
//   the state enum (MUL_IDLE, MUL_RUN, MUL_DONE);
//   localparam MUL_WIDTH_DEF = 32;
//   the shared rep-width function, also used by the divider.
//  Sub-module mult_sign_fix (combinational) holds operand abs() and result negate.
//   It is instantiated only under SEQ_MULT_SIGNED_EN.
//  Everything else is one sequential process plus the adder.
// TESTING
//  1. 3*5, start 1 cycle: fin rises exactly 32 edges after accept; prod=64'h0000_0000_0000_000F; busy low at fin.
//  2. 32'hFFFF_FFFF*32'hFFFF_FFFF -> prod=64'hFFFF_FFFE_0000_0001 (carry path).
//     Also 0*32'h1234_5678 -> prod=0 after 32 cycles.
//  3. start again at cycle 10 of RUN with other operands: ignored; result is the first product; fin at cycle 32.
//  4. reset asserted mid-RUN (rep=17), asynchronously between edges: outputs 0 immediately, IDLE.
//     A following 7*6 gives 42.
//  5. start held high: back-to-back 2*3, then 4*5. fin is high one cycle each; prod=6, then 20.
//     The second accept happens on the edge after the first DONE.
//  6. 32'hFFFF_FFFD*5:
//     without SEQ_MULT_SIGNED_EN -> 64'h0000_0004_FFFF_FFF1;
//     with it -> 64'hFFFF_FFFF_FFFF_FFF1 (-15);
//     32'h8000_0000*32'h8000_0000 -> 64'h4000_0000_0000_0000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared arithmetic-unit definitions for the sequential multiplier
// (and the companion divider): FSM state type, default width and
// the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

    localparam int unsigned MUL_WIDTH_DEF = 32;

    // Bits needed to count 0..n inclusive without wrapping.
    function automatic int unsigned rep_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// start/fin handshake bundle for seq_multiplier.
// master = requester (drives operands), slave = the multiplier.
import mult_pkg::*;

interface seq_multiplier_if #(
    parameter int unsigned WIDTH = MUL_WIDTH_DEF
);
    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic [2*WIDTH-1:0]     prod;
    logic                   fin;
    logic                   busy;

    modport master (
        output start, mcand, mplier,
        input  prod, fin, busy
    );

    modport slave (
        input  start, mcand, mplier,
        output prod, fin, busy
    );
endinterface

// File: rtl/mult_sign_fix.sv
// Combinational sign handling for the signed build of seq_multiplier:
// operand magnitudes, result sign, and final conditional negate.
import mult_pkg::*;

module mult_sign_fix #(
    parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] mag_prod,
    input  logic               neg_in,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               neg,
    output logic [2*WIDTH-1:0] prod_out
);

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag    = a[WIDTH-1] ? -a : a;
        b_mag    = b[WIDTH-1] ? -b : b;
        neg      = a[WIDTH-1] ^ b[WIDTH-1];
        prod_out = neg_in ? -mag_prod : mag_prod;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// WIDTH-bit operands, 2*WIDTH-bit product, fixed WIDTH-cycle latency.
// Optional build macro: SEQ_MULT_SIGNED_EN (two's complement operands).
import mult_pkg::*;

module seq_multiplier #(
    parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  bus
);

    localparam int unsigned REP_W = rep_width(WIDTH);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(WIDTH - 1);

    mul_state_e             state_q, state_d;
    logic                   accept;
    logic                   last;

    logic [WIDTH-1:0]       mc_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH:0]         sum;
    logic [REP_W-1:0]       rep_q;
    logic [2*WIDTH-1:0]     prod_q;
    logic                   fin_q;
    logic                   busy_q;

    logic [WIDTH-1:0]       mc_in;
    logic [WIDTH-1:0]       mp_in;
    logic [2*WIDTH-1:0]     prod_fin;

`ifdef SEQ_MULT_SIGNED_EN
    logic                   neg_in;
    logic                   neg_q;

    mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a        (bus.mcand),
        .b        (bus.mplier),
        .mag_prod (acc_next),
        .neg_in   (neg_q),
        .a_mag    (mc_in),
        .b_mag    (mp_in),
        .neg      (neg_in),
        .prod_out (prod_fin)
    );

    // Result sign captured with the operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            neg_q <= 1'b0;
        else if (accept)
            neg_q <= neg_in;
    end
`else
    assign mc_in    = bus.mcand;
    assign mp_in    = bus.mplier;
    assign prod_fin = acc_next;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= MUL_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: accept start only when idle or done; leave RUN after iteration WIDTH.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (rep_q == REP_LAST) begin
                    last    = 1'b1;
                    state_d = MUL_DONE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // One shift-add step. The carry out of the add lands in the top
    // product bit after the shift, so the spare accumulator bit above
    // 2*WIDTH is always zero and is not stored.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mc_q : '0)};
        acc_next = {sum, acc_q[WIDTH-1:1]};
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_q   <= '0;
            acc_q  <= '0;
            rep_q  <= '0;
            prod_q <= '0;
            fin_q  <= 1'b0;
            busy_q <= 1'b0;
        end else if (accept) begin
            mc_q   <= mc_in;
            acc_q  <= {{WIDTH{1'b0}}, mp_in};
            rep_q  <= '0;
            busy_q <= 1'b1;
            fin_q  <= 1'b0;
        end else if (state_q == MUL_RUN) begin
            acc_q <= acc_next;
            rep_q <= rep_q + 1'b1;
            if (last) begin
                prod_q <= prod_fin;
                fin_q  <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.prod = prod_q;
    assign bus.fin  = fin_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=32): directed vector
// table, multi-cycle corner sequences and random operands checked
// against a plain-arithmetic reference product.
import mult_pkg::*;

module tb_seq_multiplier;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one multiply; optionally raise start again at RUN cycle 'inject'.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int inject,
                           output logic [63:0] p, output int lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("fin_after_accept", 64'(bus.fin), 64'd0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.fin) begin
                lat = c;
                break;
            end
            if (c == inject) begin
                bus.start  = 1'b1;
                bus.mcand  = a ^ 32'h5A5A_0001;
                bus.mplier = b + 32'd7;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        p = bus.prod;
        chk("busy_at_fin", 64'(bus.busy), 64'd0);
    endtask

    logic [63:0] p, held;
    logic [31:0] ra, rb;
    int          lat;

    initial begin
        vecs[0] = '{"mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F};
`ifdef SEQ_MULT_SIGNED_EN
        vecs[1] = '{"mul_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{"mul_fffd_5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1};
`else
        vecs[1] = '{"mul_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{"mul_fffd_5", 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1};
`endif
        vecs[2] = '{"mul_zero", 32'd0, 32'h1234_5678, 64'h0};
        vecs[4] = '{"mul_min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[5] = '{"mul_7x6", 32'd7, 32'd6, 64'd42};

        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
        reset      = 1'b1;
        #1;
        chk("reset_prod", bus.prod, 64'h0);
        chk("reset_fin", 64'(bus.fin), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].a, vecs[i].b, 0, p, lat);
            chk(vecs[i].name, p, vecs[i].exp);
            chk("latency", 64'(lat), 64'd32);
        end

        // fin and prod hold in DONE with no new start
        held = bus.prod;
        repeat (3) @(negedge clk);
        chk("fin_held", 64'(bus.fin), 64'd1);
        chk("prod_held", bus.prod, 64'd42);

        // start during RUN is ignored
        run_mul(32'd9, 32'd11, 10, p, lat);
        chk("start_in_run_ignored", p, 64'd99);
        chk("latency_inject", 64'(lat), 64'd32);
        repeat (2) @(negedge clk);
        chk("no_reaccept_busy", 64'(bus.busy), 64'd0);

        // async reset in the middle of RUN (after 17 iterations)
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mcand  = 32'hDEAD_BEEF;
        bus.mplier = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (17) @(negedge clk);
        chk("busy_before_reset", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_prod", bus.prod, 64'h0);
        chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
        chk("midrun_reset_fin", 64'(bus.fin), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_busy", 64'(bus.busy), 64'd0);
        run_mul(32'd7, 32'd6, 0, p, lat);
        chk("after_reset_7x6", p, 64'd42);

        // start held high: back-to-back 2*3 then 4*5
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mcand  = 32'd2;
        bus.mplier = 32'd3;
        lat = -1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (bus.fin) begin
                lat = c;
                break;
            end
        end
        chk("b2b_first_latency", 64'(lat), 64'd32);
        chk("b2b_first_prod", bus.prod, 64'd6);
        bus.mcand  = 32'd4;
        bus.mplier = 32'd5;
        @(negedge clk);
        chk("b2b_fin_one_cycle", 64'(bus.fin), 64'd0);
        chk("b2b_reaccept_busy", 64'(bus.busy), 64'd1);
        chk("b2b_prod_kept", bus.prod, 64'd6);
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.fin) begin
                lat = c;
                break;
            end
        end
        chk("b2b_second_latency", 64'(lat), 64'd32);
        chk("b2b_second_prod", bus.prod, 64'd20);

        // Random operands against the reference product
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = 32'hFFFF_FFFF;
            if (i % 6 == 1) rb = 32'h8000_0000;
            if (i % 6 == 2) ra = 32'h0;
            run_mul(ra, rb, (i % 3 == 0) ? 5 : 0, p, lat);
            chk("random_prod", p, model(ra, rb));
            chk("random_latency", 64'(lat), 64'd32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
